data_mem_responder: RTL and testbench

//  Data-memory side of the DR load/store path: answers control-unit read and write strobes.

---
 rtl/data_mem_responder_if.sv | 16 +
 rtl/data_mem_responder.sv | 85 ++++++++
 tb/tb_data_mem_responder.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/data_mem_responder_if.sv
// data_mem_responder_if: control-unit/DR request and response bundle for the data memory
interface data_mem_responder_if #(parameter int reg_width = 12, parameter int addr_width = 8);
   logic                  mem_read;
   logic                  mem_write;
   logic [addr_width-1:0] addr;
   logic [reg_width-1:0]  DR_datain;
   logic [reg_width-1:0]  DM_dataout;
   logic                  busy;
   logic                  rd_valid;
   logic                  wr_done;
   logic                  err;
   modport master (output mem_read, mem_write, addr, DR_datain,
                   input DM_dataout, busy, rd_valid, wr_done, err);
   modport slave  (input mem_read, mem_write, addr, DR_datain,
                   output DM_dataout, busy, rd_valid, wr_done, err);
endinterface

// File: rtl/data_mem_responder.sv
// data_mem_responder: data RAM answering read/write strobes with fixed-latency reads and done pulses
module data_mem_responder #(
   parameter int reg_width  = 12,
   parameter int addr_width = 8,
   parameter int rd_latency = 2
) (
   input logic clk,
   input logic reset,
   data_mem_responder_if.slave bus
);
   typedef enum logic [1:0] {IDLE, READ, WRITE} state_t;
   localparam logic [3:0] lat_m1 = 4'(rd_latency - 1);
   state_t                state_q, state_d;
   logic [3:0]            cnt_q, cnt_d;
   logic [addr_width-1:0] addr_q, addr_d;
   logic [reg_width-1:0]  data_q, data_d, dout_q, dout_d;
   logic                  busy_q, busy_d, rd_valid_q, rd_valid_d, wr_done_q, wr_done_d, err_q, err_d;
   logic [reg_width-1:0]  mem [2**addr_width];
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      addr_d     = addr_q;
      data_d     = data_q;
      dout_d     = dout_q;
      err_d      = err_q;
      rd_valid_d = 1'b0;
      wr_done_d  = 1'b0;
      case (state_q)
         IDLE:
            if (bus.mem_read && bus.mem_write) err_d = 1'b1;
            else if (bus.mem_read) begin
               state_d = READ;
               addr_d  = bus.addr;
               cnt_d   = lat_m1;
            end else if (bus.mem_write) begin
               state_d = WRITE;
               addr_d  = bus.addr;
               data_d  = bus.DR_datain;
            end
         READ:
            if (cnt_q != 4'd0) cnt_d = cnt_q - 4'd1;
            else begin
               dout_d     = mem[addr_q];
               rd_valid_d = 1'b1;
               state_d    = IDLE;
            end
         WRITE: begin
            wr_done_d = 1'b1;
            state_d   = IDLE;
         end
         default: state_d = IDLE;
      endcase
      busy_d = state_d != IDLE;
   end
   always_ff @(posedge clk or negedge reset)
      if (!reset) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         addr_q     <= '0;
         data_q     <= '0;
         dout_q     <= '0;
         busy_q     <= 1'b0;
         rd_valid_q <= 1'b0;
         wr_done_q  <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         addr_q     <= addr_d;
         data_q     <= data_d;
         dout_q     <= dout_d;
         busy_q     <= busy_d;
         rd_valid_q <= rd_valid_d;
         wr_done_q  <= wr_done_d;
         err_q      <= err_d;
      end
   // RAM has no reset; an aborted write never reaches here because reset forces IDLE at once
   always_ff @(posedge clk)
      if (state_q == WRITE) mem[addr_q] <= data_q;
   assign bus.DM_dataout = dout_q;
   assign bus.busy       = busy_q;
   assign bus.rd_valid   = rd_valid_q;
   assign bus.wr_done    = wr_done_q;
   assign bus.err        = err_q;
endmodule

// File: tb/tb_data_mem_responder.sv
// tb_data_mem_responder: directed and random checks of two responders (read latency 2 and 1)
module tb_data_mem_responder;
   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic [1:0]  rd = '0, wr = '0;
   logic [7:0]  addr = '0;
   logic [11:0] din = '0;
   int          checks = 0, failures = 0;
   int          lat [2] = '{2, 1};
   logic [11:0] ref_mem [2][256];
   logic [1:0]  busy_w, rdv_w, wrd_w, err_w;
   logic [11:0] dout_w [2];
   data_mem_responder_if bus0 ();
   data_mem_responder_if bus1 ();
   data_mem_responder #(.reg_width(12), .addr_width(8), .rd_latency(2)) u0 (.clk(clk), .reset(reset), .bus(bus0));
   data_mem_responder #(.reg_width(12), .addr_width(8), .rd_latency(1)) u1 (.clk(clk), .reset(reset), .bus(bus1));
   assign bus0.mem_read  = rd[0];
   assign bus0.mem_write = wr[0];
   assign bus0.addr      = addr;
   assign bus0.DR_datain = din;
   assign bus1.mem_read  = rd[1];
   assign bus1.mem_write = wr[1];
   assign bus1.addr      = addr;
   assign bus1.DR_datain = din;
   assign busy_w    = {bus1.busy, bus0.busy};
   assign rdv_w     = {bus1.rd_valid, bus0.rd_valid};
   assign wrd_w     = {bus1.wr_done, bus0.wr_done};
   assign err_w     = {bus1.err, bus0.err};
   assign dout_w[0] = bus0.DM_dataout;
   assign dout_w[1] = bus1.DM_dataout;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_idle_outputs(input int s, input logic exp_err);
      chk("rst_busy", busy_w[s], 0);
      chk("rst_rdv", rdv_w[s], 0);
      chk("rst_wrd", wrd_w[s], 0);
      chk("rst_err", err_w[s], exp_err);
      chk("rst_dout", dout_w[s], 0);
   endtask

   task automatic do_write(input int s, input logic [7:0] a, input logic [11:0] d);
      int n = 0;
      @(negedge clk);
      addr = a; din = d; wr[s] = 1'b1;
      @(posedge clk); #1;
      chk("wr_busy", busy_w[s], 1);
      addr = 8'($urandom); din = 12'($urandom);
      do begin @(posedge clk); #1; n++; end while (!wrd_w[s] && n < 20);
      wr[s] = 1'b0;
      chk("wr_latency", n, 1);
      chk("wr_done", wrd_w[s], 1);
      chk("wr_not_busy", busy_w[s], 0);
      chk("wr_no_rdv", rdv_w[s], 0);
      ref_mem[s][a] = d;
      @(posedge clk); #1;
      chk("wr_pulse_width", wrd_w[s], 0);
   endtask

   task automatic do_read(input int s, input logic [7:0] a);
      int n = 0;
      @(negedge clk);
      addr = a; rd[s] = 1'b1;
      @(posedge clk); #1;
      chk("rd_busy", busy_w[s], 1);
      addr = 8'($urandom); din = 12'($urandom);
      do begin @(posedge clk); #1; n++; end while (!rdv_w[s] && n < 20);
      rd[s] = 1'b0;
      chk("rd_latency", n, lat[s]);
      chk("rd_data", dout_w[s], ref_mem[s][a]);
      chk("rd_not_busy", busy_w[s], 0);
      chk("rd_no_wrd", wrd_w[s], 0);
      @(posedge clk); #1;
      chk("rd_pulse_width", rdv_w[s], 0);
      chk("rd_data_held", dout_w[s], ref_mem[s][a]);
   endtask

   initial begin
      repeat (3) @(posedge clk);
      #1;
      chk_idle_outputs(0, 0);
      chk_idle_outputs(1, 0);
      @(negedge clk) reset = 1'b1;
      do_write(0, 8'h05, 12'hABC);
      do_read(0, 8'h05);
      do_write(0, 8'h10, 12'h3C3);
      @(negedge clk);
      addr = 8'h10; din = 12'h999; rd[0] = 1'b1; wr[0] = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         chk("conf_err", err_w[0], 1);
         chk("conf_busy", busy_w[0], 0);
         chk("conf_pulses", {rdv_w[0], wrd_w[0]}, 0);
      end
      rd[0] = 1'b0; wr[0] = 1'b0;
      do_read(0, 8'h10);
      chk("err_sticky", err_w[0], 1);
      chk("err_other_inst", err_w[1], 0);
      do_write(0, 8'h01, 12'h5A5);
      @(negedge clk);
      addr = 8'h01; rd[0] = 1'b1;
      @(posedge clk); #1;
      chk("bi_busy0", busy_w[0], 1);
      @(negedge clk);
      rd[0] = 1'b0; wr[0] = 1'b1; din = 12'h123;
      @(posedge clk); #1;
      chk("bi_busy1", busy_w[0], 1);
      chk("bi_no_wrd1", wrd_w[0], 0);
      @(posedge clk); #1;
      chk("bi_rdv", rdv_w[0], 1);
      chk("bi_data", dout_w[0], 12'h5A5);
      wr[0] = 1'b0;
      repeat (2) begin
         @(posedge clk); #1;
         chk("bi_no_wrd2", wrd_w[0], 0);
         chk("bi_idle", busy_w[0], 0);
      end
      do_read(0, 8'h01);
      do_write(0, 8'h20, 12'h246);
      @(negedge clk);
      addr = 8'h20; din = 12'hFFF; wr[0] = 1'b1;
      @(posedge clk); #1;
      chk("ab_busy", busy_w[0], 1);
      #2 reset = 1'b0;
      #1;
      chk_idle_outputs(0, 0);
      chk_idle_outputs(1, 0);
      wr[0] = 1'b0;
      repeat (3) begin
         @(posedge clk); #1;
         chk("ab_no_wrd", wrd_w[0], 0);
         chk("ab_no_busy", busy_w[0], 0);
      end
      @(negedge clk) reset = 1'b1;
      do_read(0, 8'h20);
      for (int s = 0; s < 2; s++) begin
         do_write(s, 8'hFF, 12'h000);
         do_write(s, 8'h00, 12'hFFF);
         do_read(s, 8'hFF);
         do_read(s, 8'h00);
         do_write(s, 8'hFF, 12'hFFF);
         do_write(s, 8'h00, 12'h000);
         do_read(s, 8'hFF);
         do_read(s, 8'h00);
      end
      for (int s = 0; s < 2; s++)
         for (int a = 0; a < 8; a++) do_write(s, 8'(a), 12'($urandom));
      for (int i = 0; i < 40; i++) begin
         int s = int'($urandom_range(1, 0));
         if ($urandom_range(1, 0) == 1) do_write(s, 8'($urandom_range(7, 0)), 12'($urandom));
         do_read(s, 8'($urandom_range(7, 0)));
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
